instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 199 +++++++++++++++++++
 tb/tb_instr_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// ==================================================================
// instr_encoder: RV32I field-to-word encoder with 2-entry result FIFO
// Rev 1.0
// ==================================================================
module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count,
  output logic [7:0]  err_count
);

  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  logic        w_imm_i_ok;
  logic        w_imm_b_ok;
  logic        w_imm_j_ok;
  logic        w_imm_u_ok;
  logic        w_shamt_ok;
  logic        w_f7_alt;
  logic        w_bad;
  logic [31:0] w_raw;
  logic [32:0] w_entry;
  logic        w_push;
  logic        w_pop;

  logic [1:0]  r_occ;
  logic [32:0] r_head;
  logic [32:0] r_tail;
  logic [15:0] r_enc_count;
  logic [7:0]  r_err_count;

  // Immediate range checks: upper bits must replicate the format's sign bit.
  always_comb begin
    w_imm_i_ok = (in_imm[31:11] == {21{in_imm[11]}});
    w_imm_b_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
    w_imm_j_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
    w_imm_u_ok = (in_imm[11:0] == 12'd0);
    w_shamt_ok = (in_imm[31:5] == 27'd0);
    w_f7_alt   = (in_funct7 == 7'h00) || (in_funct7 == 7'h20);
  end

  always_comb begin
    w_raw = 32'd0;
    w_bad = 1'b0;
    case (in_class)
      4'd0: begin
        w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_LOAD};
        w_bad = !w_imm_i_ok;
      end
      4'd1: begin
        w_raw = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], c_OPC_STORE};
        w_bad = !w_imm_i_ok;
      end
      4'd2: begin
        w_raw = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], c_OPC_BRANCH};
        w_bad = !w_imm_b_ok;
      end
      4'd3: begin
        w_raw = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, c_OPC_JAL};
        w_bad = !w_imm_j_ok;
      end
      4'd4: begin
        w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_JALR};
        w_bad = !w_imm_i_ok;
      end
      4'd5: begin
        w_raw = {in_imm[31:12], in_rd, c_OPC_LUI};
        w_bad = !w_imm_u_ok;
      end
      4'd6: begin
        w_raw = {in_imm[31:12], in_rd, c_OPC_AUIPC};
        w_bad = !w_imm_u_ok;
      end
      4'd7: begin
        // Shifts carry funct7 in the upper immediate bits and a 5-bit shamt.
        if (in_funct3 == 3'b001) begin
          w_raw = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, c_OPC_OPIMM};
          w_bad = (in_funct7 != 7'h00) || !w_shamt_ok;
        end else if (in_funct3 == 3'b101) begin
          w_raw = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, c_OPC_OPIMM};
          w_bad = !w_f7_alt || !w_shamt_ok;
        end else begin
          w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_OPIMM};
          w_bad = !w_imm_i_ok;
        end
      end
      4'd8: begin
        w_raw = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, c_OPC_OP};
        w_bad = !w_f7_alt ||
                ((in_funct7 == 7'h20) && (in_funct3 != 3'b000) && (in_funct3 != 3'b101));
      end
      4'd9: begin
        w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_FENCE};
        w_bad = !w_imm_i_ok;
      end
      4'd10: begin
        w_raw = {in_imm[11:0], in_rs1, in_funct3, in_rd, c_OPC_SYSTEM};
        w_bad = !w_imm_i_ok;
      end
      default: begin
        w_raw = 32'd0;
        w_bad = 1'b1;
      end
    endcase
  end

  assign w_entry  = w_bad ? {1'b1, 32'd0} : {1'b0, w_raw};
  assign in_ready = (r_occ != c_FULL) && !reset;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_occ != c_EMPTY) && out_ready;

  // r_head is the output register; r_tail only holds the second entry when FULL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ       <= c_EMPTY;
      r_head      <= 33'd0;
      r_tail      <= 33'd0;
      r_enc_count <= 16'd0;
      r_err_count <= 8'd0;
    end else begin
      case (r_occ)
        c_EMPTY: begin
          if (w_push) begin
            r_head <= w_entry;
            r_occ  <= c_ONE;
          end
        end
        c_ONE: begin
          if (w_push && w_pop) begin
            r_head <= w_entry;
          end else if (w_push) begin
            r_tail <= w_entry;
            r_occ  <= c_FULL;
          end else if (w_pop) begin
            r_head <= 33'd0;
            r_occ  <= c_EMPTY;
          end
        end
        c_FULL: begin
          if (w_pop) begin
            r_head <= r_tail;
            r_tail <= 33'd0;
            r_occ  <= c_ONE;
          end
        end
        default: begin
          r_head <= 33'd0;
          r_tail <= 33'd0;
          r_occ  <= c_EMPTY;
        end
      endcase

      if (w_push) begin
        if (w_entry[32]) begin
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end else begin
          r_enc_count <= r_enc_count + 16'd1;
        end
      end
    end
  end

  assign out_valid = (r_occ != c_EMPTY);
  assign out_instr = r_head[31:0];
  assign out_err   = r_head[32];
  assign enc_count = r_enc_count;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ==================================================================
// tb_instr_encoder: randomized bench with queue-based reference model
// Rev 1.0
// ==================================================================
module tb_instr_encoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  instr_encoder u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit m_live = 1'b0;

  logic [32:0] m_q[$];
  logic [15:0] m_enc;
  logic [7:0]  m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
  endtask

  // Reference encoder: field placement by shifts and masks, legality by numeric ranges.
  function automatic logic [32:0] ref_encode(input int cls, input int f3, input int f7,
                                             input int rd, input int rs1, input int rs2,
                                             input logic [31:0] imm);
    int     op_tab[11] = '{3, 35, 99, 111, 103, 55, 23, 19, 51, 15, 115};
    longint s = longint'($signed(imm));
    longint u = longint'({32'd0, imm});
    longint w = 0;
    bit     ok = 1'b0;
    bit     i_ok = (s >= -2048) && (s <= 2047);
    longint fld = (longint'(rd) << 7) | (longint'(f3) << 12) | (longint'(rs1) << 15);
    if (cls > 10) return {1'b1, 32'd0};
    case (cls)
      0, 4, 9, 10: begin ok = i_ok; w = ((u & 4095) << 20) | fld; end
      7: begin
        if (f3 == 1 || f3 == 5) begin
          ok = (u <= 31) && (f7 == 0 || (f3 == 5 && f7 == 32));
          w  = (longint'(f7) << 25) | ((u & 31) << 20) | fld;
        end else begin
          ok = i_ok;
          w  = ((u & 4095) << 20) | fld;
        end
      end
      1: begin
        ok = i_ok;
        w  = (((u >> 5) & 127) << 25) | (longint'(rs2) << 20) | (longint'(rs1) << 15)
           | (longint'(f3) << 12) | ((u & 31) << 7);
      end
      2: begin
        ok = (s >= -4096) && (s <= 4095) && (u % 2 == 0);
        w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (longint'(rs2) << 20)
           | (longint'(rs1) << 15) | (longint'(f3) << 12) | (((u >> 1) & 15) << 8)
           | (((u >> 11) & 1) << 7);
      end
      3: begin
        ok = (s >= -(longint'(1) << 20)) && (s < (longint'(1) << 20)) && (u % 2 == 0);
        w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
           | (((u >> 12) & 255) << 12) | (longint'(rd) << 7);
      end
      5, 6: begin ok = (u % 4096 == 0); w = (u & 64'hFFFF_F000) | (longint'(rd) << 7); end
      8: begin
        ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        w  = (longint'(f7) << 25) | (longint'(rs2) << 20) | fld;
      end
      default: ok = 1'b0;
    endcase
    w = w | longint'(op_tab[cls]);
    return ok ? {1'b0, w[31:0]} : {1'b1, 32'd0};
  endfunction

  // Model update at each active edge (inputs change only at posedge+1).
  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_enc = 16'd0;
      m_err = 8'd0;
    end else begin
      bit acc;
      bit pop;
      logic [32:0] e;
      acc = in_valid && (m_q.size() < 2);
      pop = (m_q.size() > 0) && out_ready;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        e = ref_encode(int'(in_class), int'(in_funct3), int'(in_funct7), int'(in_rd),
                       int'(in_rs1), int'(in_rs2), in_imm);
        m_q.push_back(e);
        if (e[32]) begin
          if (m_err != 8'hFF) m_err = m_err + 8'd1;
        end else begin
          m_enc = m_enc + 16'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic [32:0] hd;
      hd = (m_q.size() > 0) ? m_q[0] : 33'd0;
      check("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
      check("out_instr", out_instr, hd[31:0]);
      check("out_err", {31'd0, out_err}, {31'd0, hd[32]});
      check("in_ready", {31'd0, in_ready}, {31'd0, (m_q.size() < 2) && !reset});
      check("enc_count", {16'd0, enc_count}, {16'd0, m_enc});
      check("err_count", {24'd0, err_count}, {24'd0, m_err});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int cls, input int f3, input int f7, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_class  = cls[3:0];
    in_funct3 = f3[2:0];
    in_funct7 = f7[6:0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_imm    = imm;
  endtask

  function automatic logic [31:0] rand_imm();
    int          edge_tab[12] = '{2047, 2048, -2048, -2049, 4095, 4094, -4096, -4098,
                                  31, 32, 1048574, -1048576};
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 7))
      0: return 32'(int'($urandom_range(0, 80)) - 40);
      1: return 32'(edge_tab[$urandom_range(0, 11)]);
      2: return r;
      3: return r & 32'hFFFF_F000;
      4: return 32'($urandom_range(0, 33));
      5: return {{11{r[20]}}, r[20:0]};
      6: return {{19{r[12]}}, r[12:0]};
      default: return {{20{r[11]}}, r[11:0]};
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_class = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick();
    m_live = 1'b1;
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_enc_count", {16'd0, enc_count}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    send(7, 0, 0, 1, 0, 0, 32'd5); tick(); in_valid = 1'b0;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_word", out_instr, 32'h0050_0093);
    check("addi_err", {31'd0, out_err}, 32'd0);
    check("addi_enc_count", {16'd0, enc_count}, 32'd1);
    tick();
    send(1, 2, 0, 0, 1, 2, 32'd8); tick(); in_valid = 1'b0;
    check("sw_word", out_instr, 32'h0020_A423);
    tick();
    send(5, 0, 0, 5, 0, 0, 32'h1234_5000); tick(); in_valid = 1'b0;
    check("lui_word", out_instr, 32'h1234_52B7);
    tick();
    send(3, 0, 0, 1, 0, 0, 32'd8); tick(); in_valid = 1'b0;
    check("jal_word", out_instr, 32'h0080_00EF);
    tick();
    send(2, 0, 0, 0, 0, 0, 32'd3); tick(); in_valid = 1'b0;
    check("bad_branch_word", out_instr, 32'd0);
    check("bad_branch_err", {31'd0, out_err}, 32'd1);
    check("bad_branch_err_count", {24'd0, err_count}, 32'd1);
    tick();

    // Back-pressure: two fill the FIFO, the third waits.
    out_ready = 1'b0;
    send(7, 0, 0, 1, 0, 0, 32'd1); tick();
    check("bp_ready_one", {31'd0, in_ready}, 32'd1);
    send(7, 0, 0, 1, 0, 0, 32'd2); tick();
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    send(7, 0, 0, 1, 0, 0, 32'd3); tick(); tick();
    check("bp_held_ready", {31'd0, in_ready}, 32'd0);
    check("bp_head_stable", out_instr, 32'h0010_0093);
    check("bp_enc_count", {16'd0, enc_count}, 32'd6);
    out_ready = 1'b1; tick();
    check("bp_second", out_instr, 32'h0020_0093);
    tick(); in_valid = 1'b0;
    check("bp_third", out_instr, 32'h0030_0093);
    check("bp_enc_count3", {16'd0, enc_count}, 32'd7);
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);
    check("bp_drained_word", out_instr, 32'd0);

    // Reset while FULL with a request also offered.
    out_ready = 1'b0;
    send(7, 0, 0, 1, 0, 0, 32'd1); tick();
    send(7, 0, 0, 1, 0, 0, 32'd2); tick();
    check("full_before_rst", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    send(7, 0, 0, 1, 0, 0, 32'd3); tick();
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_enc", {16'd0, enc_count}, 32'd0);
    check("midrst_err", {24'd0, err_count}, 32'd0);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    tick();
    check("midrst_discard", {31'd0, out_valid}, 32'd0);

    // Error counter saturation.
    out_ready = 1'b1;
    send(15, 0, 0, 0, 0, 0, 32'd0);
    repeat (256) tick();
    in_valid = 1'b0;
    check("err_saturate", {24'd0, err_count}, 32'h0000_00FF);
    tick();

    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      send($urandom_range(0, 15), $urandom_range(0, 7),
           ($urandom_range(0, 2) == 0) ? 32 : (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 127)),
           $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), rand_imm());
      in_valid = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Good-word counter wraps.
    reset = 1'b1; in_valid = 1'b0; tick();
    reset = 1'b0; out_ready = 1'b1;
    send(7, 0, 0, 1, 0, 0, 32'd1);
    repeat (65535) tick();
    check("enc_max", {16'd0, enc_count}, 32'h0000_FFFF);
    tick(); in_valid = 1'b0;
    check("enc_wrap", {16'd0, enc_count}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
